// File: rtl/axi_channel_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_channel_fifo: single-clock AXI channel buffer with FWFT output,        |
// | occupancy/LAST counters, flush and optional store-and-forward mode.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi_channel_fifo #(
  parameter int WIDTH        = 37,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2,
  parameter int PACKET_MODE  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_flush,
  input  logic [WIDTH-1:0]             i_in_data,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  output logic [WIDTH-1:0]             o_out_data,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic [$clog2(DEPTH+1)-1:0]   o_pkt_cnt,
  output logic                         o_empty
);

  localparam int c_LW = $clog2(DEPTH + 1);
  localparam int c_PW = $clog2(DEPTH);
  localparam logic [c_LW-1:0] c_THRESH = c_LW'(DEPTH - AFULL_MARGIN);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_LW-1:0]  r_level;
  logic [c_LW-1:0]  r_pkt_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_empty;
  logic             r_cut;

  logic             w_push;
  logic             w_pop;
  logic [c_LW-1:0]  w_stored;
  logic [c_LW-1:0]  w_level_next;
  logic [c_LW-1:0]  w_pkt_next;
  logic             w_below;
  logic             w_cut_next;
  logic             w_eligible;
  logic             w_out_free;
  logic             w_from_mem;
  logic             w_load;
  logic             w_wr_en;

  always_comb begin
    w_push       = i_in_valid && r_in_ready;
    w_pop        = r_out_valid && i_out_ready;
    w_stored     = r_level - c_LW'(r_out_valid);
    w_level_next = r_level + c_LW'(w_push) - c_LW'(w_pop);
    w_pkt_next   = r_pkt_cnt + c_LW'(w_push && i_in_data[0])
                             - c_LW'(w_pop && r_out_data[0]);
    w_below      = (w_level_next < c_THRESH);
    // Once the threshold releases a LAST-less burst, keep cutting through
    // until the buffer drains, otherwise the tail of the burst is stranded.
    w_cut_next   = (r_cut || !w_below) && (w_level_next != '0);
    w_eligible   = (PACKET_MODE == 0) || (w_pkt_next != '0) || w_cut_next;
    w_out_free   = !r_out_valid || w_pop;
    w_from_mem   = (w_stored != '0);
    w_load       = w_out_free && w_eligible && (w_from_mem || w_push);
    w_wr_en      = w_push && !(w_load && !w_from_mem) && !i_flush;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pkt_cnt   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_empty     <= 1'b1;
      r_cut       <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pkt_cnt   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_empty     <= 1'b1;
      r_cut       <= 1'b0;
    end else begin
      r_level    <= w_level_next;
      r_pkt_cnt  <= w_pkt_next;
      r_in_ready <= w_below;
      r_empty    <= (w_level_next == '0);
      r_cut      <= w_cut_next;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_load && w_from_mem) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_from_mem ? r_mem[r_rd_ptr] : i_in_data;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_level     = r_level;
  assign o_pkt_cnt   = r_pkt_cnt;
  assign o_empty     = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_axi_channel_fifo.sv
`default_nettype none
// Directed testbench for axi_channel_fifo: a stream instance (16/2) and a
// packet-mode instance (8/0) sharing clock and reset.
module tb_axi_channel_fifo;
  localparam int W = 37;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         s_flush = 1'b0;
  logic [W-1:0] s_in_data = '0;
  logic         s_in_valid = 1'b0;
  logic         s_in_ready;
  logic [W-1:0] s_out_data;
  logic         s_out_valid;
  logic         s_out_ready = 1'b0;
  logic [4:0]   s_level;
  logic [4:0]   s_pkt;
  logic         s_empty;

  logic         p_flush = 1'b0;
  logic [W-1:0] p_in_data = '0;
  logic         p_in_valid = 1'b0;
  logic         p_in_ready;
  logic [W-1:0] p_out_data;
  logic         p_out_valid;
  logic         p_out_ready = 1'b0;
  logic [3:0]   p_level;
  logic [3:0]   p_pkt;
  logic         p_empty;

  int checks   = 0;
  int failures = 0;

  axi_channel_fifo #(.WIDTH(W), .DEPTH(16), .AFULL_MARGIN(2), .PACKET_MODE(0)) u_stream (
    .clk(clk), .rst_n(rst_n), .i_flush(s_flush),
    .i_in_data(s_in_data), .i_in_valid(s_in_valid), .o_in_ready(s_in_ready),
    .o_out_data(s_out_data), .o_out_valid(s_out_valid), .i_out_ready(s_out_ready),
    .o_level(s_level), .o_pkt_cnt(s_pkt), .o_empty(s_empty)
  );

  axi_channel_fifo #(.WIDTH(W), .DEPTH(8), .AFULL_MARGIN(0), .PACKET_MODE(1)) u_packet (
    .clk(clk), .rst_n(rst_n), .i_flush(p_flush),
    .i_in_data(p_in_data), .i_in_valid(p_in_valid), .o_in_ready(p_in_ready),
    .o_out_data(p_out_data), .o_out_valid(p_out_valid), .i_out_ready(p_out_ready),
    .o_level(p_level), .o_pkt_cnt(p_pkt), .o_empty(p_empty)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (s_in_ready !== 1'b0 || s_out_valid !== 1'b0 || s_out_data !== '0)
      begin failures++; $display("FAIL reset_out: ready=%b valid=%b data=%0h expected 0 0 0", s_in_ready, s_out_valid, s_out_data); end
    checks++; if (s_level !== 5'd0 || s_pkt !== 5'd0 || s_empty !== 1'b1)
      begin failures++; $display("FAIL reset_cnt: level=%0d pkt=%0d empty=%b expected 0 0 1", s_level, s_pkt, s_empty); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (s_in_ready !== 1'b1 || p_in_ready !== 1'b1)
      begin failures++; $display("FAIL reset_ready: s=%b p=%b expected 1 1", s_in_ready, p_in_ready); end
  endtask

  task automatic test_fill_drain;
    int acc = 0;
    s_out_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      s_in_data  = W'(i);
      s_in_valid = 1'b1;
      if (s_in_ready) acc++;
      step();
    end
    s_in_valid = 1'b0;
    checks++; if (acc != 14) begin failures++; $display("FAIL fill_accepted: got %0d expected 14", acc); end
    checks++; if (s_in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b expected 0", s_in_ready); end
    checks++; if (s_level !== 5'd14) begin failures++; $display("FAIL fill_level: got %0d expected 14", s_level); end
    checks++; if (s_pkt !== 5'd7) begin failures++; $display("FAIL fill_pkt: got %0d expected 7", s_pkt); end
    s_out_ready = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== W'(k) || s_level !== 5'(15 - k)) begin
        failures++;
        $display("FAIL drain_%0d: valid=%b data=%0h level=%0d expected 1 %0h %0d", k, s_out_valid, s_out_data, s_level, k, 15 - k);
      end
      if (k == 2) begin
        checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL drain_ready: got %b expected 1", s_in_ready); end
      end
      step();
    end
    s_out_ready = 1'b0;
    checks++;
    if (s_out_valid !== 1'b0 || s_out_data !== '0 || s_level !== 5'd0 || s_empty !== 1'b1 || s_pkt !== 5'd0) begin
      failures++;
      $display("FAIL drain_end: valid=%b data=%0h level=%0d empty=%b pkt=%0d expected 0 0 0 1 0", s_out_valid, s_out_data, s_level, s_empty, s_pkt);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] base = 37'h10_0000_0000;
    s_out_ready = 1'b1;
    s_in_valid  = 1'b1;
    s_in_data   = base;
    step();
    for (int i = 1; i < 100; i++) begin
      s_in_data = base + W'(i);
      checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== base + W'(i - 1) || s_level !== 5'd1) begin
        failures++;
        $display("FAIL b2b_%0d: valid=%b data=%0h level=%0d expected 1 %0h 1", i, s_out_valid, s_out_data, s_level, base + W'(i - 1));
      end
      step();
    end
    s_in_valid = 1'b0;
    checks++; if (s_out_data !== base + W'(99)) begin failures++; $display("FAIL b2b_last: got %0h expected %0h", s_out_data, base + W'(99)); end
    step();
    s_out_ready = 1'b0;
    checks++; if (s_out_valid !== 1'b0 || s_out_data !== '0 || s_empty !== 1'b1)
      begin failures++; $display("FAIL b2b_idle: valid=%b data=%0h empty=%b expected 0 0 1", s_out_valid, s_out_data, s_empty); end
  endtask

  task automatic test_packet;
    logic [W-1:0] words [4];
    words[0] = 37'h10; words[1] = 37'h12; words[2] = 37'h14; words[3] = 37'h17;
    p_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p_in_data  = words[i];
      p_in_valid = 1'b1;
      checks++;
      if (p_out_valid !== 1'b0 || p_pkt !== 4'd0) begin
        failures++; $display("FAIL pkt_hold_%0d: valid=%b pkt=%0d expected 0 0", i, p_out_valid, p_pkt);
      end
      step();
    end
    p_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (p_out_valid !== 1'b1 || p_out_data !== words[i] || p_pkt !== 4'd1) begin
        failures++;
        $display("FAIL pkt_out_%0d: valid=%b data=%0h pkt=%0d expected 1 %0h 1", i, p_out_valid, p_out_data, p_pkt, words[i]);
      end
      step();
    end
    checks++; if (p_out_valid !== 1'b0 || p_pkt !== 4'd0 || p_level !== 4'd0)
      begin failures++; $display("FAIL pkt_end: valid=%b pkt=%0d level=%0d expected 0 0 0", p_out_valid, p_pkt, p_level); end
  endtask

  task automatic test_escape;
    logic [W-1:0] exp_w [9];
    int got = 0;
    logic pushing;
    for (int i = 0; i < 8; i++) exp_w[i] = 37'h20 + W'(2 * i);
    exp_w[8] = 37'h30;
    p_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p_in_data  = exp_w[i];
      p_in_valid = 1'b1;
      checks++;
      if (p_out_valid !== 1'b0 || p_level !== 4'(i)) begin
        failures++; $display("FAIL esc_hold_%0d: valid=%b level=%0d expected 0 %0d", i, p_out_valid, p_level, i);
      end
      step();
    end
    checks++;
    if (p_out_valid !== 1'b1 || p_out_data !== exp_w[0] || p_level !== 4'd8 || p_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL esc_release: valid=%b data=%0h level=%0d ready=%b expected 1 20 8 0", p_out_valid, p_out_data, p_level, p_in_ready);
    end
    p_in_data   = exp_w[8];
    p_in_valid  = 1'b1;
    p_out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 9; c++) begin
      if (p_out_valid) begin
        checks++;
        if (p_out_data !== exp_w[got]) begin
          failures++; $display("FAIL esc_word_%0d: got %0h expected %0h", got, p_out_data, exp_w[got]);
        end
        got++;
      end
      pushing = p_in_valid && p_in_ready;
      step();
      if (pushing) p_in_valid = 1'b0;
    end
    p_in_valid  = 1'b0;
    p_out_ready = 1'b0;
    checks++; if (got != 9 || p_level !== 4'd0 || p_empty !== 1'b1)
      begin failures++; $display("FAIL esc_done: delivered=%0d level=%0d empty=%b expected 9 0 1", got, p_level, p_empty); end
  endtask

  task automatic test_flush;
    s_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_in_data  = 37'h41 + W'(i);
      s_in_valid = 1'b1;
      step();
    end
    checks++; if (s_level !== 5'd5 || s_out_valid !== 1'b1 || s_pkt !== 5'd3)
      begin failures++; $display("FAIL flush_pre: level=%0d valid=%b pkt=%0d expected 5 1 3", s_level, s_out_valid, s_pkt); end
    s_in_data = 37'h55;
    s_flush   = 1'b1;
    step();
    s_flush    = 1'b0;
    s_in_valid = 1'b0;
    checks++;
    if (s_level !== 5'd0 || s_pkt !== 5'd0 || s_out_valid !== 1'b0 || s_out_data !== '0 || s_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: level=%0d pkt=%0d valid=%b data=%0h ready=%b expected 0 0 0 0 0", s_level, s_pkt, s_out_valid, s_out_data, s_in_ready);
    end
    step();
    checks++; if (s_in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready: got %b expected 1", s_in_ready); end
    s_in_data  = 37'hAA;
    s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    checks++; if (s_out_valid !== 1'b1 || s_out_data !== 37'hAA || s_level !== 5'd1)
      begin failures++; $display("FAIL flush_first: valid=%b data=%0h level=%0d expected 1 aa 1", s_out_valid, s_out_data, s_level); end
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    checks++; if (s_out_valid !== 1'b0 || s_level !== 5'd0)
      begin failures++; $display("FAIL flush_drain: valid=%b level=%0d expected 0 0", s_out_valid, s_level); end
  endtask

  task automatic test_async_reset;
    s_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_in_data  = 37'h61 + W'(i);
      s_in_valid = 1'b1;
      step();
    end
    s_in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_in_ready !== 1'b0 || s_out_valid !== 1'b0 || s_out_data !== '0 || s_level !== 5'd0 || s_pkt !== 5'd0 || s_empty !== 1'b1) begin
      failures++;
      $display("FAIL arst_now: ready=%b valid=%b data=%0h level=%0d pkt=%0d empty=%b expected 0 0 0 0 0 1", s_in_ready, s_out_valid, s_out_data, s_level, s_pkt, s_empty);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0 || s_level !== 5'd0)
      begin failures++; $display("FAIL arst_release: ready=%b valid=%b level=%0d expected 1 0 0", s_in_ready, s_out_valid, s_level); end
    s_in_data  = 37'h71;
    s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    checks++; if (s_out_valid !== 1'b1 || s_out_data !== 37'h71 || s_level !== 5'd1)
      begin failures++; $display("FAIL arst_fresh: valid=%b data=%0h level=%0d expected 1 71 1", s_out_valid, s_out_data, s_level); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_packet();
    test_escape();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
